// File: rtl/decoder_3x8_arbiter.sv
// ----------------------------------------------------------------------------
// decoder_3x8_arbiter
//
// Round-robin arbiter that shares one 3-to-8 decoder between eight requesters.
// The winner's index is driven onto A/B/C (A = MSB) and EN is raised, so only
// the winner's decoder output goes high. A grant is held until the holder
// pulses DONE or drops its request, and every grant is followed by exactly one
// EN=0 cycle (GAP) so two grants never touch.
//
// Optional feature, macro DECODER_ARB_TIMEOUT_EN:
//   defined   - a grant is forcibly released after MAX_HOLD cycles and
//               TIMEOUT pulses for the following GAP cycle.
//   undefined - no hold counter; MAX_HOLD is unused; TIMEOUT is tied low.
// ----------------------------------------------------------------------------
module decoder_3x8_arbiter #(
  parameter int unsigned MAX_HOLD = 16    // legal range 1..255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic       EN,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       BUSY,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] last, last_nxt;     // most recent winner; search starts after it
  logic [2:0] sel, sel_nxt;       // index currently driven on A/B/C
  logic       en_q, en_nxt;
  logic       busy_q, busy_nxt;
  logic [2:0] winner;
  logic       any_req;
  logic       release_req;

`ifdef DECODER_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       timeout_q, timeout_nxt;
`endif

  // Round-robin pick: rotate the request vector so that bit 0 corresponds to
  // last+1, take the lowest set bit, and add the offset back (mod 8). If only
  // the previous winner is requesting it is found at offset 7 and wins again.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last_w);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  start;
    logic [2:0]  ofs;
    logic        found;
    start = last_w + 3'd1;
    dbl   = {req, req};
    rot   = dbl[start +: 8];
    ofs   = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && rot[k]) begin
        ofs   = 3'(k);
        found = 1'b1;
      end
    end
    return start + ofs;
  endfunction

  assign winner      = rr_pick(REQ, last);
  assign any_req     = |REQ;
  assign release_req = DONE || !REQ[sel];

  // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
`ifdef DECODER_ARB_TIMEOUT_EN
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
`endif
    unique case (state)
      ST_IDLE, ST_GAP: begin
        // GAP differs from IDLE only in that it is always left after
        // one cycle; both start a fresh grant if anyone is asking.
        if (any_req) begin
          state_nxt = ST_GRANT;
          sel_nxt   = winner;
          last_nxt  = winner;
`ifdef DECODER_ARB_TIMEOUT_EN
          hold_cnt_nxt = 8'd0;
`endif
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A/B/C stay frozen; only the holder's request and DONE matter.
        if (release_req) begin
          state_nxt = ST_GAP;
        end
`ifdef DECODER_ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          state_nxt   = ST_GAP;
          timeout_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    en_nxt   = (state_nxt == ST_GRANT);
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State register and registered outputs; reset drops EN without a clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      last   <= 3'd7;
      sel    <= 3'd0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state  <= state_nxt;
      last   <= last_nxt;
      sel    <= sel_nxt;
      en_q   <= en_nxt;
      busy_q <= busy_nxt;
    end
  end

`ifdef DECODER_ARB_TIMEOUT_EN
  // Hold counter and the one-cycle TIMEOUT pulse for a forced release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign EN   = en_q;
  assign A    = sel[2];
  assign B    = sel[1];
  assign C    = sel[0];
  assign BUSY = busy_q;

endmodule

// File: tb/tb_decoder_3x8_arbiter.sv
// ----------------------------------------------------------------------------
// tb_decoder_3x8_arbiter
//
// Directed scenarios followed by random REQ/DONE traffic, all compared each
// cycle against a behavioural model that tracks "who holds the decoder" and
// "was there just a break cycle". Honours DECODER_ARB_TIMEOUT_EN (MAX_HOLD=4).
// ----------------------------------------------------------------------------
module tb_decoder_3x8_arbiter;

`ifdef DECODER_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam int MH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [7:0] REQ = 8'h00;
  logic       DONE = 1'b0;
  logic       EN, A, B, C, BUSY, TIMEOUT;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_holder;   // requester holding the decoder, -1 when none
  bit m_gap;      // in the break cycle after a release
  int m_last;     // most recent winner
  int m_held;     // cycles the current holder has held EN
  int m_sel;      // index shown on A/B/C
  bit m_to;       // timeout pulse

  decoder_3x8_arbiter #(.MAX_HOLD(MH)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .REQ     (REQ),
    .DONE    (DONE),
    .EN      (EN),
    .A       (A),
    .B       (B),
    .C       (C),
    .BUSY    (BUSY),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int lst);
    for (int d = 1; d <= 8; d++) begin
      if (r[(lst + d) % 8]) return (lst + d) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_gap    = 1'b0;
    m_last   = 7;
    m_held   = 0;
    m_sel    = 0;
    m_to     = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    m_to = 1'b0;
    if (m_holder >= 0) begin
      if (DONE || !REQ[m_holder]) begin
        m_holder = -1;
        m_gap    = 1'b1;
      end else if (TIMEOUT_ON && m_held == MH) begin
        m_holder = -1;
        m_gap    = 1'b1;
        m_to     = 1'b1;
      end else begin
        m_held++;
      end
    end else if (REQ != 8'h00) begin
      m_holder = pick(REQ, m_last);
      m_last   = m_holder;
      m_sel    = m_holder;
      m_held   = 1;
      m_gap    = 1'b0;
    end else begin
      m_gap = 1'b0;
    end
  endtask

  function automatic logic [5:0] model_out();
    logic en_m;
    en_m = (m_holder >= 0);
    return {en_m, 3'(m_sel), en_m || m_gap, m_to};
  endfunction

  // One clock: model steps at the edge, outputs are compared 1 ns later.
  task automatic cycle(input string tag);
    @(posedge CLK);
    model_step();
    #1;
    check(tag, {26'd0, EN, A, B, C, BUSY, TIMEOUT}, {26'd0, model_out()});
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", {26'd0, EN, A, B, C, BUSY, TIMEOUT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    REQ   = 8'h00;
    DONE  = 1'b0;
  endtask

  logic [2:0] order[$];

  initial begin
    // Idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) cycle("idle");
    check("idle_busy", {31'd0, BUSY}, 32'd0);

    // Single requester 0: grant, DONE after 3 cycles, one gap, re-grant
    REQ = 8'h01;
    cycle("single_grant");
    check("single_en", {31'd0, EN}, 32'd1);
    check("single_abc", {29'd0, A, B, C}, 32'd0);
    cycle("single_hold");
    cycle("single_hold");
    DONE = 1'b1;
    cycle("single_release");
    check("single_gap_en", {31'd0, EN}, 32'd0);
    DONE = 1'b0;
    cycle("single_regrant");
    check("single_regrant_en", {31'd0, EN}, 32'd1);

    // Reset in the middle of a grant
    do_reset();

    // All requesting: strict rotation 0..7,0 with one gap between grants
    REQ = 8'hFF;
    for (int n = 0; n < 60 && order.size() < 9; n++) begin
      cycle("rr_step");
      if (EN && !DONE) begin
        order.push_back({A, B, C});
        DONE = 1'b1;
      end else begin
        DONE = 1'b0;
      end
    end
    DONE = 1'b0;
    check("rr_grant_count", order.size(), 9);
    for (int i = 0; i < order.size(); i++) check("rr_order", order[i], i % 8);

    // Wrap from 7 to 4, then request drop releases 4 and 7 wins
    do_reset();
    REQ = 8'h80;
    cycle("wrap_grant7");
    check("wrap_abc7", {29'd0, A, B, C}, 32'd7);
    REQ  = 8'h90;
    DONE = 1'b1;
    cycle("wrap_gap");
    DONE = 1'b0;
    cycle("wrap_grant4");
    check("wrap_abc4", {29'd0, A, B, C}, 32'd4);
    REQ = 8'h80;
    cycle("drop_gap");
    check("drop_gap_en", {31'd0, EN}, 32'd0);
    cycle("drop_grant7");
    check("drop_abc7", {29'd0, A, B, C}, 32'd7);

    do_reset();
`ifdef DECODER_ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD cycles, then DONE on the last cycle
    REQ = 8'h0C;
    for (int i = 0; i < MH; i++) begin
      cycle("to_hold2");
      check("to_hold2_en", {31'd0, EN}, 32'd1);
    end
    cycle("to_gap");
    check("to_pulse", {31'd0, TIMEOUT}, 32'd1);
    cycle("to_grant3");
    check("to_abc3", {29'd0, A, B, C}, 32'd3);
    check("to_pulse_off", {31'd0, TIMEOUT}, 32'd0);
    for (int i = 1; i < MH - 1; i++) cycle("to_hold3");
    DONE = 1'b1;
    cycle("to_done_last");
    check("to_done_no_pulse", {31'd0, TIMEOUT}, 32'd0);
    DONE = 1'b0;
`else
    // No timeout: a held request keeps the grant indefinitely
    REQ = 8'h02;
    for (int i = 0; i < 300; i++) cycle("long_hold");
    check("long_hold_en", {31'd0, EN}, 32'd1);
    check("long_hold_abc", {29'd0, A, B, C}, 32'd1);
    check("long_hold_to", {31'd0, TIMEOUT}, 32'd0);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) REQ = 8'($urandom);
      DONE = ($urandom_range(3) == 0);
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
